controle_jogo: RTL and testbench

- Game-flow controller that sequences the LED-matrix puzzle datapath.
- Debounces the eight raw puzzle buttons and serializes their presses into single-cycle, one-hot toggle pulses for the matrix.
- Drives the current level and the matrix clear, waits for the matrix's registered level-complete flag, and advances the level or ends the game on win or per-level timeout.

---
 rtl/controle_jogo_if.sv | 25 ++
 rtl/controle_jogo.sv | 151 +++++++++++++++
 tb/tb_controle_jogo.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/controle_jogo_if.sv
// Signal bundle between the game-flow controller and its surroundings (buttons, start request, LED matrix).
// pulso_botoes and limpa_matriz are one-cycle commands with no back-pressure: the matrix must act on every cycle they are high.
interface controle_jogo_if;
    logic       iniciar;
    logic [7:0] botoes;
    logic       nivel_concluido;
    logic [7:0] pulso_botoes;
    logic       limpa_matriz;
    logic [2:0] nivel;
    logic [7:0] jogadas;
    logic       vitoria;
    logic       derrota;
    logic       jogando;
    logic [2:0] db_estado;

    modport master (
        output iniciar, botoes, nivel_concluido,
        input  pulso_botoes, limpa_matriz, nivel, jogadas, vitoria, derrota, jogando, db_estado
    );

    modport slave (
        input  iniciar, botoes, nivel_concluido,
        output pulso_botoes, limpa_matriz, nivel, jogadas, vitoria, derrota, jogando, db_estado
    );
endinterface

// File: rtl/controle_jogo.sv
// Game-flow controller: debounces the puzzle buttons, serializes presses into one-hot toggle pulses,
// and sequences levels against a per-level timeout.
module controle_jogo #(
    parameter int          DEBOUNCE_CICLOS = 50000,
    parameter logic [31:0] TEMPO_NIVEL     = 32'd3000000000,
    parameter logic [2:0]  MAX_NIVEL       = 3'd4,
    parameter int          LAT_CHECA       = 2
) (
    input logic            clk,
    input logic            rst,
    controle_jogo_if.slave bus
);
    localparam int DB_W  = $clog2(DEBOUNCE_CICLOS + 1);
    localparam int LAT_W = $clog2(LAT_CHECA + 1);
    localparam logic [DB_W-1:0]  DB_LIM   = DB_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [LAT_W-1:0] LAT_ULT  = LAT_W'(LAT_CHECA - 1);

    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        LIMPA      = 3'd1,
        JOGANDO    = 3'd2,
        CHECA      = 3'd3,
        PROX_NIVEL = 3'd4,
        VITORIA    = 3'd5,
        DERROTA    = 3'd6
    } estado_t;

    estado_t          estado, prox;
    logic [7:0]       amostra, estavel, pendente;
    logic [DB_W-1:0]  db_cnt;
    logic [31:0]      timer;
    logic [LAT_W-1:0] espera;
    logic [2:0]       nivel_r;
    logic [7:0]       jogadas_r;

    logic       mudou, aceita;
    logic [7:0] subida, concede, pulso;
    logic       limpa, inativo;

    // One shared counter: any change anywhere in the vector restarts the settle window.
    assign mudou   = (bus.botoes != amostra);
    assign aceita  = !mudou && (db_cnt == DB_LIM);
    assign subida  = aceita ? (bus.botoes & ~estavel) : 8'd0;
    assign concede = pendente & (~pendente + 8'd1);

    always_comb begin
        prox    = estado;
        pulso   = 8'd0;
        limpa   = 1'b0;
        inativo = 1'b0;
        case (estado)
            INICIAL: begin
                inativo = 1'b1;
                if (bus.iniciar) prox = LIMPA;
            end
            LIMPA: begin
                limpa = 1'b1;
                prox  = JOGANDO;
            end
            JOGANDO: begin
                if (timer == 32'd0) begin
                    prox = DERROTA;
                end else if (pendente != 8'd0) begin
                    pulso = concede;
                    prox  = CHECA;
                end
            end
            CHECA: begin
                // On the sampling cycle a completed level beats an expiring timer.
                if (espera == LAT_ULT) begin
                    if (bus.nivel_concluido)
                        prox = (nivel_r == MAX_NIVEL) ? VITORIA : PROX_NIVEL;
                    else if (timer == 32'd0)
                        prox = DERROTA;
                    else
                        prox = JOGANDO;
                end else if (timer == 32'd0) begin
                    prox = DERROTA;
                end
            end
            PROX_NIVEL: begin
                limpa = 1'b1;
                prox  = JOGANDO;
            end
            VITORIA, DERROTA: begin
                inativo = 1'b1;
                if (bus.iniciar) prox = LIMPA;
            end
            default: prox = INICIAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= INICIAL;
            amostra   <= 8'd0;
            estavel   <= 8'd0;
            db_cnt    <= '0;
            pendente  <= 8'd0;
            timer     <= 32'd0;
            espera    <= '0;
            nivel_r   <= 3'd0;
            jogadas_r <= 8'd0;
        end else begin
            estado  <= prox;
            amostra <= bus.botoes;

            if (mudou)
                db_cnt <= '0;
            else if (db_cnt != DB_LIM)
                db_cnt <= db_cnt + 1'b1;

            if (aceita)
                estavel <= bus.botoes;

            if (inativo || limpa)
                pendente <= 8'd0;
            else
                pendente <= (pendente & ~pulso) | subida;

            if (limpa)
                timer <= TEMPO_NIVEL;
            else if ((estado == JOGANDO || estado == CHECA) && timer != 32'd0)
                timer <= timer - 32'd1;

            if (estado == CHECA && espera != LAT_ULT)
                espera <= espera + 1'b1;
            else
                espera <= '0;

            if (prox == LIMPA)
                nivel_r <= 3'd0;
            else if (estado == PROX_NIVEL && nivel_r != MAX_NIVEL)
                nivel_r <= nivel_r + 3'd1;

            if (limpa)
                jogadas_r <= 8'd0;
            else if (pulso != 8'd0 && jogadas_r != 8'hFF)
                jogadas_r <= jogadas_r + 8'd1;
        end
    end

    assign bus.pulso_botoes = pulso;
    assign bus.limpa_matriz = limpa;
    assign bus.nivel        = nivel_r;
    assign bus.jogadas      = jogadas_r;
    assign bus.vitoria      = (estado == VITORIA);
    assign bus.derrota      = (estado == DERROTA);
    assign bus.jogando      = (estado == JOGANDO) || (estado == CHECA);
    assign bus.db_estado    = estado;
endmodule

// File: tb/tb_controle_jogo.sv
// Randomized bench for controle_jogo: a press-level model queues the expected toggle pulses,
// a negedge monitor pops and compares them, and directed checks follow level/game outcomes.
module tb_controle_jogo;
    localparam int         DEB   = 4;
    localparam int         TEMPO = 200;
    localparam int         LAT   = 2;
    localparam logic [2:0] MAXN  = 3'd4;

    logic clk = 1'b0;
    logic rst;

    controle_jogo_if bus ();

    controle_jogo #(
        .DEBOUNCE_CICLOS(DEB),
        .TEMPO_NIVEL    (32'(TEMPO)),
        .MAX_NIVEL      (MAXN),
        .LAT_CHECA      (LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    int ciclo = 0;
    int ultimo_pulso = -100;
    int ultimo_gap = 0;
    int n_limpa = 0;
    logic [7:0] mon_e;
    logic completar = 1'b0;
    logic c1 = 1'b0;
    logic c2 = 1'b0;
    int exp_nivel;
    int exp_jogadas;
    int exp_limpa;

    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual === esperado)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
    endtask

    // Matrix stand-in: when armed, raises the registered completion flag two cycles after a pulse.
    always @(negedge clk) begin
        bus.nivel_concluido = c2;
        c2 = c1;
        c1 = completar && (bus.pulso_botoes != 8'd0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.limpa_matriz) n_limpa++;
            if (bus.pulso_botoes != 8'd0) begin
                check("pulso_onehot", 32'($onehot(bus.pulso_botoes)), 32'd1);
                check("pulso_sem_limpa", 32'(bus.limpa_matriz), 32'd0);
                if (exp_q.size() == 0) begin
                    check("pulso_inesperado", 32'(bus.pulso_botoes), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulso", 32'(bus.pulso_botoes), 32'(mon_e));
                end
                ultimo_gap = ciclo - ultimo_pulso;
                check("pulso_espaco", 32'(ultimo_gap >= LAT + 1), 32'd1);
                ultimo_pulso = ciclo;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] m, input int hold, input bit aceito);
        bus.botoes = m;
        if (aceito)
            for (int i = 0; i < 8; i++)
                if (m[i]) begin
                    exp_q.push_back(8'(1 << i));
                    exp_jogadas++;
                end
        repeat (hold) tick();
        bus.botoes = 8'd0;
        repeat (DEB + 2) tick();
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 80) begin
            tick();
            t++;
        end
        check("fila_vazia", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) tick();
    endtask

    task automatic iniciar_jogo(output int t_limpa);
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        t_limpa = ciclo;
        exp_limpa++;
        exp_nivel   = 0;
        exp_jogadas = 0;
        check("limpa_pulso", 32'(bus.limpa_matriz), 32'd1);
        check("estado_limpa", 32'(bus.db_estado), 32'd1);
        tick();
        check("limpa_fim", 32'(bus.limpa_matriz), 32'd0);
        check("jogando", 32'(bus.jogando), 32'd1);
        check("estado_jogando", 32'(bus.db_estado), 32'd2);
        check("nivel_inicio", 32'(bus.nivel), 32'd0);
        check("jogadas_inicio", 32'(bus.jogadas), 32'd0);
    endtask

    task automatic check_zerado(input string fase);
        check({fase, "_pulso"}, 32'(bus.pulso_botoes), 32'd0);
        check({fase, "_limpa"}, 32'(bus.limpa_matriz), 32'd0);
        check({fase, "_nivel"}, 32'(bus.nivel), 32'd0);
        check({fase, "_jogadas"}, 32'(bus.jogadas), 32'd0);
        check({fase, "_vitoria"}, 32'(bus.vitoria), 32'd0);
        check({fase, "_derrota"}, 32'(bus.derrota), 32'd0);
        check({fase, "_jogando"}, 32'(bus.jogando), 32'd0);
        check({fase, "_estado"}, 32'(bus.db_estado), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_limpa, t;
        int b;
        logic [7:0] m;

        exp_limpa   = 0;
        exp_nivel   = 0;
        exp_jogadas = 0;
        rst         = 1'b1;
        bus.iniciar = 1'b0;
        bus.botoes  = 8'd0;
        repeat (3) tick();
        check_zerado("reset");
        rst = 1'b0;
        repeat (2) tick();

        iniciar_jogo(t_limpa);

        // Bounce shorter than the settle window, then a clean press.
        press(8'h08, 3, 1'b0);
        press(8'h08, 10, 1'b1);
        wait_drain();
        check("jogadas_b3", 32'(bus.jogadas), 32'(exp_jogadas));

        press(8'h81, 10, 1'b1);
        wait_drain();
        check("gap_81", 32'(ultimo_gap), 32'(LAT + 1));
        check("jogadas_81", 32'(bus.jogadas), 32'(exp_jogadas));

        for (int lv = 0; lv <= 4; lv++) begin
            if (lv > 0) begin
                m = 8'($urandom_range(1, 255));
                press(m, $urandom_range(DEB + 1, DEB + 6), 1'b1);
                wait_drain();
                check("jogadas_rand", 32'(bus.jogadas), 32'(exp_jogadas));
            end
            b = $urandom_range(0, 7);
            completar = 1'b1;
            press(8'(1 << b), $urandom_range(DEB + 1, DEB + 6), 1'b1);
            wait_drain();
            completar = 1'b0;
            if (lv < 4) begin
                exp_nivel++;
                exp_limpa++;
                exp_jogadas = 0;
                check("nivel_avanca", 32'(bus.nivel), 32'(exp_nivel));
                check("jogadas_zera", 32'(bus.jogadas), 32'(exp_jogadas));
                check("estado_nivel", 32'(bus.db_estado), 32'd2);
            end else begin
                check("vitoria", 32'(bus.vitoria), 32'd1);
                check("nivel_max", 32'(bus.nivel), 32'(MAXN));
                check("estado_vitoria", 32'(bus.db_estado), 32'd5);
                check("jogando_vit", 32'(bus.jogando), 32'd0);
            end
        end
        press(8'h20, 8, 1'b0);
        check("vitoria_mantida", 32'(bus.vitoria), 32'd1);

        // Timeout run: one random press, then nothing completes the level.
        iniciar_jogo(t_limpa);
        m = 8'($urandom_range(1, 255));
        press(m, $urandom_range(DEB + 1, DEB + 6), 1'b1);
        wait_drain();
        t = 0;
        while (!bus.derrota && t < 400) begin
            tick();
            t++;
        end
        check("derrota", 32'(bus.derrota), 32'd1);
        t = ciclo - t_limpa - 1;
        check("tempo_derrota", 32'(t >= TEMPO && t <= TEMPO + 1), 32'd1);
        press(8'h10, 8, 1'b0);
        check("derrota_mantida", 32'(bus.derrota), 32'd1);
        check("estado_derrota", 32'(bus.db_estado), 32'd6);
        check("jogando_der", 32'(bus.jogando), 32'd0);

        // Reset while a second press is still pending behind the first grant.
        iniciar_jogo(t_limpa);
        bus.botoes = 8'h06;
        exp_q.push_back(8'h02);
        t = 0;
        @(negedge clk);
        while (bus.pulso_botoes == 8'd0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("pulso_antes_reset", 32'(bus.pulso_botoes), 32'h02);
        tick();
        check("estado_checa", 32'(bus.db_estado), 32'd3);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_zerado("reset_checa");
        rst = 1'b0;
        bus.botoes = 8'd0;
        repeat (10) tick();
        iniciar_jogo(t_limpa);
        repeat (30) tick();
        check("sem_replay", 32'(bus.jogadas), 32'd0);
        check("fila_final", 32'(exp_q.size()), 32'd0);
        check("limpa_total", 32'(n_limpa), 32'(exp_limpa));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
